// File: rtl/riscv_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : riscv_run_ctrl
// Purpose  : Run sequencer for riscv_pipeline. Holds the core in reset for
//            RESET_CYCLES after start, releases it, watches the PC until a
//            stop address is reached or a cycle budget expires, drains the
//            pipeline, pulses dump for one cycle and reports completion.
//            Counts register writebacks (x0 excluded) for bookkeeping.
// Ports    : clk        - clock, rising edge
//            reset      - synchronous active-high reset
//            start      - begin a run (honoured in IDLE and DONE only)
//            stop_pc    - stop address, unsigned compare against pc_out
//            pc_out     - core program counter
//            wb_e/wb_a  - core writeback enable / destination register
//            core_reset - drives core reset
//            dump       - one-cycle dump request to the core
//            busy       - run in progress (HOLD, RUN, DRAIN, DUMP)
//            done       - run complete (DONE)
//            timed_out  - last run ended on the cycle budget
//            run_cycles - RUN cycles of the last/current run (saturating)
//            wb_count   - writebacks to x1..x31 in RUN/DRAIN (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module riscv_run_ctrl #(
  parameter int RESET_CYCLES   = 20,
  parameter int DRAIN_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] stop_pc,
  input  logic [31:0] pc_out,
  input  logic        wb_e,
  input  logic [4:0]  wb_a,
  output logic        core_reset,
  output logic        dump,
  output logic        busy,
  output logic        done,
  output logic        timed_out,
  output logic [31:0] run_cycles,
  output logic [15:0] wb_count
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HOLD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DUMP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [31:0] C_RESET_LOAD = 32'(RESET_CYCLES);
  localparam logic [31:0] C_DRAIN_LOAD = 32'(DRAIN_CYCLES);
  // run_cycles still holds the pre-increment count when compared
  localparam logic [31:0] C_TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic        C_NO_DRAIN   = (DRAIN_CYCLES == 0);

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [31:0] r_cnt;          // shared HOLD / DRAIN down-counter
  logic [31:0] r_run_cycles;
  logic [15:0] r_wb_count;
  logic        r_timed_out;
  logic        r_core_reset;
  logic        r_dump;
  logic        r_busy;
  logic        r_done;

  logic        w_stop_hit;
  logic        w_tmo_hit;
  logic        w_run_end;
  logic        w_core_reset_nxt;
  logic        w_dump_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;

  assign w_stop_hit = (pc_out >= stop_pc);
  assign w_tmo_hit  = (r_run_cycles == C_TMO_LAST);
  assign w_run_end  = w_stop_hit || w_tmo_hit;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_cnt <= 32'd1) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_run_end) begin
          w_next = C_NO_DRAIN ? S_DUMP : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_cnt <= 32'd1) begin
          w_next = S_DUMP;
        end
      end
      S_DUMP: begin
        w_next = S_DONE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic (decoded from the next state, then registered so every
  // control output is glitch-free and aligned with the state it describes)
  // --------------------------------------------------------------------------
  always_comb begin
    w_core_reset_nxt = 1'b0;
    w_dump_nxt       = 1'b0;
    w_busy_nxt       = 1'b0;
    w_done_nxt       = 1'b0;
    case (w_next)
      S_IDLE: begin
        w_core_reset_nxt = 1'b1;
      end
      S_HOLD: begin
        w_core_reset_nxt = 1'b1;
        w_busy_nxt       = 1'b1;
      end
      S_RUN, S_DRAIN: begin
        w_busy_nxt = 1'b1;
      end
      S_DUMP: begin
        w_dump_nxt = 1'b1;
        w_busy_nxt = 1'b1;
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
      end
      default: begin
        w_core_reset_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_core_reset <= 1'b1;
      r_dump       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_core_reset <= w_core_reset_nxt;
      r_dump       <= w_dump_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencing counter, run statistics and timeout flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= 32'd0;
      r_run_cycles <= 32'd0;
      r_timed_out  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_cnt        <= C_RESET_LOAD;
            r_run_cycles <= 32'd0;
            r_timed_out  <= 1'b0;
          end
        end
        S_HOLD: begin
          r_cnt <= r_cnt - 32'd1;
        end
        S_RUN: begin
          if (r_run_cycles != 32'hFFFF_FFFF) begin
            r_run_cycles <= r_run_cycles + 32'd1;
          end
          if (w_run_end) begin
            r_cnt <= C_DRAIN_LOAD;
          end
          // A stop hit on the budget's last cycle is a normal finish
          if (w_tmo_hit && !w_stop_hit) begin
            r_timed_out <= 1'b1;
          end
        end
        S_DRAIN: begin
          r_cnt <= r_cnt - 32'd1;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Writeback monitor: x0 writes are architecturally discarded, so skip them
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_count <= 16'd0;
    end else if ((r_state == S_IDLE || r_state == S_DONE) && start) begin
      r_wb_count <= 16'd0;
    end else if ((r_state == S_RUN || r_state == S_DRAIN) && wb_e &&
                 (wb_a != 5'd0) && (r_wb_count != 16'hFFFF)) begin
      r_wb_count <= r_wb_count + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. core_reset also follows reset directly so the core is held in
  // reset in the very cycle the controller sees reset, not one cycle later.
  // --------------------------------------------------------------------------
  assign core_reset = r_core_reset | reset;
  assign dump       = r_dump;
  assign busy       = r_busy;
  assign done       = r_done;
  assign timed_out  = r_timed_out;
  assign run_cycles = r_run_cycles;
  assign wb_count   = r_wb_count;

endmodule
`default_nettype wire

// File: tb/tb_riscv_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_run_ctrl
// Purpose  : Directed self-checking bench for riscv_run_ctrl. Two instances:
//            u_dut with default parameters and u_dut_z with DRAIN_CYCLES=0,
//            TIMEOUT_CYCLES=4. Each drives a small PC model core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_run_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] stop_pc;
  logic        wb_e;
  logic [4:0]  wb_a;
  logic        pc_inc;

  logic [31:0] pc;
  logic        core_reset, dump, busy, done, timed_out;
  logic [31:0] run_cycles;
  logic [15:0] wb_count;

  logic [31:0] pc_z;
  logic        core_reset_z, dump_z, busy_z, done_z, timed_out_z;
  logic [31:0] run_cycles_z;
  logic [15:0] wb_count_z;

  int n_tests = 0;
  int n_fail  = 0;
  int n_dump  = 0;
  bit inv_on  = 0;

  riscv_run_ctrl u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop_pc    (stop_pc),
    .pc_out     (pc),
    .wb_e       (wb_e),
    .wb_a       (wb_a),
    .core_reset (core_reset),
    .dump       (dump),
    .busy       (busy),
    .done       (done),
    .timed_out  (timed_out),
    .run_cycles (run_cycles),
    .wb_count   (wb_count)
  );

  riscv_run_ctrl #(
    .RESET_CYCLES   (20),
    .DRAIN_CYCLES   (0),
    .TIMEOUT_CYCLES (4)
  ) u_dut_z (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop_pc    (stop_pc),
    .pc_out     (pc_z),
    .wb_e       (wb_e),
    .wb_a       (wb_a),
    .core_reset (core_reset_z),
    .dump       (dump_z),
    .busy       (busy_z),
    .done       (done_z),
    .timed_out  (timed_out_z),
    .run_cycles (run_cycles_z),
    .wb_count   (wb_count_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model cores: PC cleared while held in reset, then +4 per cycle (or stuck)
  always @(posedge clk) begin
    if (core_reset)  pc <= 32'd0;
    else if (pc_inc) pc <= pc + 32'd4;
  end
  always @(posedge clk) begin
    if (core_reset_z) pc_z <= 32'd0;
    else if (pc_inc)  pc_z <= pc_z + 32'd4;
  end

  always @(posedge clk) begin
    if (dump) n_dump++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Invariants: busy/done exclusive, dump implies busy
  always @(negedge clk) begin
    if (inv_on) begin
      check("busy_done_excl", {31'd0, busy & done}, 32'd0);
      check("dump_implies_busy", {31'd0, dump & ~busy}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start from IDLE/DONE, check the 20-cycle hold, then find the dump cycle
  // of both instances counted from RUN cycle 1.
  task automatic start_and_hold(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
    check({tag, "_core_reset_held"}, {31'd0, core_reset}, 32'd1);
    repeat (19) tick();
    check({tag, "_core_reset_last_hold"}, {31'd0, core_reset}, 32'd1);
    tick();
    check({tag, "_core_reset_released"}, {31'd0, core_reset}, 32'd0);
  endtask

  task automatic wait_dump(input string tag, input int bound, input int exp1, input int exp2);
    int d1, d2;
    d1 = 0;
    d2 = 0;
    for (int c = 1; c <= bound; c++) begin
      if (dump_z && d2 == 0) d2 = c;
      if (dump && d1 == 0) d1 = c;
      if (d1 != 0) break;
      tick();
    end
    check({tag, "_dump_cycle"}, d1, exp1);
    check({tag, "_dump_cycle_z"}, d2, exp2);
  endtask

  task automatic run_nominal(input string tag);
    int d0;
    d0 = n_dump;
    start_and_hold(tag);
    // RUN 1..4 (pc 0,4,8,12), DRAIN 5..8, DUMP 9; zero-drain DUMP at 5
    wait_dump(tag, 60, 9, 5);
    tick();
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_dump_low"}, {31'd0, dump}, 32'd0);
    check({tag, "_timed_out"}, {31'd0, timed_out}, 32'd0);
    check({tag, "_run_cycles"}, run_cycles, 32'd4);
    check({tag, "_dump_pulses"}, n_dump - d0, 32'd1);
    check({tag, "_z_done"}, {31'd0, done_z}, 32'd1);
    // stop and timeout coincide on RUN cycle 4: stop wins
    check({tag, "_z_timed_out"}, {31'd0, timed_out_z}, 32'd0);
    check({tag, "_z_run_cycles"}, run_cycles_z, 32'd4);
  endtask

  initial begin
    int d0;
    reset   = 1'b1;
    start   = 1'b0;
    stop_pc = 32'd12;
    wb_e    = 1'b0;
    wb_a    = 5'd0;
    pc_inc  = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    inv_on = 1;
    check("rst_core_reset", {31'd0, core_reset}, 32'd1);
    check("rst_flags", {28'd0, dump, busy, done, timed_out}, 32'd0);
    check("rst_run_cycles", run_cycles, 32'd0);
    check("rst_wb_count", {16'd0, wb_count}, 32'd0);

    // ---------------- Nominal run ----------------
    run_nominal("nom");

    // ---------------- Timeout ----------------
    stop_pc = 32'hFFFF_FFF0;
    pc_inc  = 1'b0;
    d0 = n_dump;
    start_and_hold("tmo");
    // RUN 1..200, DRAIN 201..204, DUMP 205; zero-drain: RUN 1..4, DUMP 5
    wait_dump("tmo", 300, 205, 5);
    tick();
    check("tmo_done", {31'd0, done}, 32'd1);
    check("tmo_timed_out", {31'd0, timed_out}, 32'd1);
    check("tmo_run_cycles", run_cycles, 32'd200);
    check("tmo_dump_pulses", n_dump - d0, 32'd1);
    check("tmo_z_timed_out", {31'd0, timed_out_z}, 32'd1);
    check("tmo_z_run_cycles", run_cycles_z, 32'd4);

    // ---------------- Start in DONE, start in RUN, writeback count ----------------
    stop_pc = 32'd12;
    pc_inc  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_from_done_timed_out", {31'd0, timed_out}, 32'd0);
    check("rst_from_done_run_cycles", run_cycles, 32'd0);
    check("rst_from_done_busy", {31'd0, busy}, 32'd1);
    repeat (5) tick();
    wb_e = 1'b1; wb_a = 5'd5;        // in HOLD: not counted
    tick();
    wb_e = 1'b0;
    repeat (13) tick();
    check("wb_core_reset_last_hold", {31'd0, core_reset}, 32'd1);
    tick();
    check("wb_core_reset_released", {31'd0, core_reset}, 32'd0);
    wb_e = 1'b1; wb_a = 5'd1;        // RUN 1
    tick();
    wb_a = 5'd2; start = 1'b1;       // RUN 2, start ignored
    tick();
    start = 1'b0;
    check("start_in_run_ignored", {31'd0, core_reset}, 32'd0);
    wb_a = 5'd0;                     // RUN 3, x0 not counted
    tick();
    wb_a = 5'd7;                     // RUN 4
    tick();
    wb_a = 5'd3;                     // DRAIN 1
    tick();
    wb_e = 1'b0; wb_a = 5'd0;
    wait_dump("wb", 20, 4, 0);       // now at DRAIN 2: dump at 4th cycle from here
    tick();
    check("wb_count", {16'd0, wb_count}, 32'd4);
    check("wb_run_cycles", run_cycles, 32'd4);
    wb_e = 1'b1; wb_a = 5'd9;        // DONE: counters frozen
    tick();
    wb_e = 1'b0;
    check("wb_frozen_in_done", {16'd0, wb_count}, 32'd4);

    // ---------------- Reset in third DRAIN cycle ----------------
    d0 = n_dump;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (26) tick();              // RUN 1 after edge 20, DRAIN 3 after edge 26
    check("mid_busy_in_drain", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_core_reset_same_cycle", {31'd0, core_reset}, 32'd1);
    tick();
    reset = 1'b0;
    check("mid_core_reset", {31'd0, core_reset}, 32'd1);
    check("mid_flags", {28'd0, dump, busy, done, timed_out}, 32'd0);
    check("mid_run_cycles", run_cycles, 32'd0);
    check("mid_wb_count", {16'd0, wb_count}, 32'd0);
    repeat (6) tick();
    check("mid_no_dump", n_dump - d0, 32'd0);
    check("mid_stays_idle", {31'd0, busy}, 32'd0);

    run_nominal("post_rst");

    inv_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
